// File: rtl/lc3_isdu_param_if.sv
// Control/status bundle between the LC-3 ISDU and the SLC-3 datapath.
// The ISDU side (master) reads status and button inputs and drives all control strobes.
interface lc3_isdu_param_if;
  logic       Run;
  logic       Continue;
  logic [3:0] Opcode;
  logic       IR_5;
  logic       IR_11;
  logic       BEN;

  logic       LD_MAR;
  logic       LD_MDR;
  logic       LD_IR;
  logic       LD_BEN;
  logic       LD_CC;
  logic       LD_REG;
  logic       LD_PC;
  logic       LD_LED;
  logic       GatePC;
  logic       GateMDR;
  logic       GateALU;
  logic       GateMARMUX;
  logic [1:0] PCMUX;
  logic       DRMUX;
  logic       SR1MUX;
  logic       SR2MUX;
  logic       ADDR1MUX;
  logic [1:0] ADDR2MUX;
  logic [1:0] ALUK;
  logic       Mem_OE;
  logic       Mem_WE;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
           GatePC, GateMDR, GateALU, GateMARMUX,
           PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
           Mem_OE, Mem_WE
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
           GatePC, GateMDR, GateALU, GateMARMUX,
           PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
           Mem_OE, Mem_WE
  );
endinterface

// File: rtl/lc3_isdu_param.sv
// LC-3 instruction sequencing and decode unit: Moore FSM driving SLC-3 datapath controls,
// with SRAM access length set by MEM_WAIT via a down-counter and an optional IR pause loop.
module lc3_isdu_param #(
  parameter int MEM_WAIT = 4,
  parameter bit PAUSE_EN = 1'b0
) (
  input logic                  Clk,
  input logic                  Reset_n,
  lc3_isdu_param_if.master     bus
);

  if (MEM_WAIT < 1 || MEM_WAIT > 15) begin : g_bad_mem_wait
    $error("lc3_isdu_param: MEM_WAIT must be in 1..15");
  end

  localparam int                CNT_W    = $clog2(MEM_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_WAIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [4:0] {
    HALTED, S18, RD_IF, S35, PAUSE_IR1, PAUSE_IR2, S32,
    S01, S05, S09, S00, S22, S12, S04, S21,
    S06, S25, S27, S07, S23, S16, S13, S14
  } state_e;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mem_oe, mem_we;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= HALTED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = '0;

    unique case (state_q)
      HALTED: if (bus.Run) state_d = S18;

      S18: begin
        ctrl.gate_pc = 1'b1;
        ctrl.ld_mar  = 1'b1;
        ctrl.ld_pc   = 1'b1;
        cnt_d        = CNT_LOAD;
        state_d      = RD_IF;
      end

      // Instruction fetch and LDR share the same counted SRAM read.
      RD_IF, S25: begin
        ctrl.mem_oe = 1'b1;
        if (cnt_q == '0) begin
          ctrl.ld_mdr = 1'b1;
          state_d     = (state_q == RD_IF) ? S35 : S27;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S35: begin
        ctrl.gate_mdr = 1'b1;
        ctrl.ld_ir    = 1'b1;
        state_d       = PAUSE_EN ? PAUSE_IR1 : S32;
      end

      PAUSE_IR1: if (bus.Continue)  state_d = PAUSE_IR2;
      PAUSE_IR2: if (!bus.Continue) state_d = S18;

      S32: begin
        ctrl.ld_ben = 1'b1;
        case (bus.Opcode)
          4'b0001: state_d = S01;
          4'b0101: state_d = S05;
          4'b1001: state_d = S09;
          4'b0000: state_d = S00;
          4'b1100: state_d = S12;
          4'b0100: state_d = S04;
          4'b0110: state_d = S06;
          4'b0111: state_d = S07;
          4'b1101: state_d = S13;
          default: state_d = S18;
        endcase
      end

      S01, S05, S09: begin
        ctrl.gate_alu = 1'b1;
        ctrl.ld_reg   = 1'b1;
        ctrl.ld_cc    = 1'b1;
        ctrl.sr1mux   = 1'b1;
        ctrl.sr2mux   = bus.IR_5;
        ctrl.aluk     = (state_q == S01) ? 2'b00 : (state_q == S05) ? 2'b01 : 2'b10;
        state_d       = S18;
      end

      S00: state_d = bus.BEN ? S22 : S18;

      S22: begin
        ctrl.ld_pc    = 1'b1;
        ctrl.addr2mux = 2'b10;
        ctrl.pcmux    = 2'b10;
        state_d       = S18;
      end

      S12: begin
        ctrl.sr1mux   = 1'b1;
        ctrl.aluk     = 2'b11;
        ctrl.gate_alu = 1'b1;
        ctrl.ld_pc    = 1'b1;
        ctrl.pcmux    = 2'b01;
        state_d       = S18;
      end

      S04: begin
        ctrl.gate_pc = 1'b1;
        ctrl.ld_reg  = 1'b1;
        ctrl.drmux   = 1'b1;
        state_d      = S21;
      end

      // IR_11 picks PC+off11 (JSR) or BaseR+0 (JSRR) through the address adder.
      S21: begin
        ctrl.ld_pc = 1'b1;
        ctrl.pcmux = 2'b10;
        if (bus.IR_11) begin
          ctrl.addr2mux = 2'b11;
        end else begin
          ctrl.sr1mux   = 1'b1;
          ctrl.addr1mux = 1'b1;
        end
        state_d = S18;
      end

      S06, S07: begin
        ctrl.sr1mux      = 1'b1;
        ctrl.addr1mux    = 1'b1;
        ctrl.addr2mux    = 2'b01;
        ctrl.gate_marmux = 1'b1;
        ctrl.ld_mar      = 1'b1;
        if (state_q == S06) begin
          cnt_d   = CNT_LOAD;
          state_d = S25;
        end else begin
          state_d = S23;
        end
      end

      S27: begin
        ctrl.gate_mdr = 1'b1;
        ctrl.ld_reg   = 1'b1;
        ctrl.ld_cc    = 1'b1;
        state_d       = S18;
      end

      // Mem_OE stays low here so the MDR input mux takes the bus, not SRAM.
      S23: begin
        ctrl.aluk     = 2'b11;
        ctrl.gate_alu = 1'b1;
        ctrl.ld_mdr   = 1'b1;
        cnt_d         = CNT_LOAD;
        state_d       = S16;
      end

      S16: begin
        ctrl.mem_we = 1'b1;
        if (cnt_q == '0) state_d = S18;
        else             cnt_d   = cnt_q - CNT_ONE;
      end

      S13: begin
        ctrl.ld_led = 1'b1;
        if (bus.Continue) state_d = S14;
      end

      S14: if (!bus.Continue) state_d = S18;

      default: state_d = HALTED;
    endcase
  end

  assign bus.LD_MAR     = ctrl.ld_mar;
  assign bus.LD_MDR     = ctrl.ld_mdr;
  assign bus.LD_IR      = ctrl.ld_ir;
  assign bus.LD_BEN     = ctrl.ld_ben;
  assign bus.LD_CC      = ctrl.ld_cc;
  assign bus.LD_REG     = ctrl.ld_reg;
  assign bus.LD_PC      = ctrl.ld_pc;
  assign bus.LD_LED     = ctrl.ld_led;
  assign bus.GatePC     = ctrl.gate_pc;
  assign bus.GateMDR    = ctrl.gate_mdr;
  assign bus.GateALU    = ctrl.gate_alu;
  assign bus.GateMARMUX = ctrl.gate_marmux;
  assign bus.PCMUX      = ctrl.pcmux;
  assign bus.DRMUX      = ctrl.drmux;
  assign bus.SR1MUX     = ctrl.sr1mux;
  assign bus.SR2MUX     = ctrl.sr2mux;
  assign bus.ADDR1MUX   = ctrl.addr1mux;
  assign bus.ADDR2MUX   = ctrl.addr2mux;
  assign bus.ALUK       = ctrl.aluk;
  assign bus.Mem_OE     = ctrl.mem_oe;
  assign bus.Mem_WE     = ctrl.mem_we;

endmodule

// File: tb/tb_lc3_isdu_param.sv
// Directed bench for lc3_isdu_param: three instances (MEM_WAIT 4/2/1, pause loop off/off/on)
// checked cycle by cycle against hand-computed control words.
module tb_lc3_isdu_param;

  logic Clk;
  logic Reset_n;

  lc3_isdu_param_if if_a ();
  lc3_isdu_param_if if_b ();
  lc3_isdu_param_if if_c ();

  lc3_isdu_param #(.MEM_WAIT(4), .PAUSE_EN(1'b0)) dut_a (.Clk(Clk), .Reset_n(Reset_n), .bus(if_a));
  lc3_isdu_param #(.MEM_WAIT(2), .PAUSE_EN(1'b0)) dut_b (.Clk(Clk), .Reset_n(Reset_n), .bus(if_b));
  lc3_isdu_param #(.MEM_WAIT(1), .PAUSE_EN(1'b1)) dut_c (.Clk(Clk), .Reset_n(Reset_n), .bus(if_c));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Control word layout, MSB first.
  localparam logic [23:0] LD_MAR  = 24'h800000, LD_MDR = 24'h400000, LD_IR  = 24'h200000;
  localparam logic [23:0] LD_BEN  = 24'h100000, LD_CC  = 24'h080000, LD_REG = 24'h040000;
  localparam logic [23:0] LD_PC   = 24'h020000, LD_LED = 24'h010000;
  localparam logic [23:0] G_PC    = 24'h008000, G_MDR  = 24'h004000, G_ALU  = 24'h002000;
  localparam logic [23:0] G_MARM  = 24'h001000;
  localparam logic [23:0] PC_BUS  = 24'h000400, PC_ADR = 24'h000800;
  localparam logic [23:0] DR_R7   = 24'h000200, SR1_86 = 24'h000100, SR2_IM = 24'h000080;
  localparam logic [23:0] A1_SR1  = 24'h000040;
  localparam logic [23:0] A2_O6   = 24'h000010, A2_O9  = 24'h000020, A2_O11 = 24'h000030;
  localparam logic [23:0] K_AND   = 24'h000004, K_NOT  = 24'h000008, K_PASS = 24'h00000C;
  localparam logic [23:0] M_OE    = 24'h000002, M_WE   = 24'h000001;

  localparam logic [23:0] E_FETCH = G_PC | LD_MAR | LD_PC;
  localparam logic [23:0] E_RD    = M_OE;
  localparam logic [23:0] E_RDL   = M_OE | LD_MDR;
  localparam logic [23:0] E_S35   = G_MDR | LD_IR;
  localparam logic [23:0] E_S32   = LD_BEN;
  localparam logic [23:0] E_MARB  = SR1_86 | A1_SR1 | A2_O6 | G_MARM | LD_MAR;

  function automatic logic [23:0] pack(input logic [7:0] ld, input logic [3:0] g,
                                       input logic [1:0] pcm, input logic [3:0] mx,
                                       input logic [1:0] a2, input logic [1:0] k,
                                       input logic oe, input logic we);
    return {ld, g, pcm, mx, a2, k, oe, we};
  endfunction

  logic [23:0] obs_a, obs_b, obs_c;
  assign obs_a = pack({if_a.LD_MAR, if_a.LD_MDR, if_a.LD_IR, if_a.LD_BEN, if_a.LD_CC, if_a.LD_REG, if_a.LD_PC, if_a.LD_LED},
                      {if_a.GatePC, if_a.GateMDR, if_a.GateALU, if_a.GateMARMUX}, if_a.PCMUX,
                      {if_a.DRMUX, if_a.SR1MUX, if_a.SR2MUX, if_a.ADDR1MUX}, if_a.ADDR2MUX, if_a.ALUK,
                      if_a.Mem_OE, if_a.Mem_WE);
  assign obs_b = pack({if_b.LD_MAR, if_b.LD_MDR, if_b.LD_IR, if_b.LD_BEN, if_b.LD_CC, if_b.LD_REG, if_b.LD_PC, if_b.LD_LED},
                      {if_b.GatePC, if_b.GateMDR, if_b.GateALU, if_b.GateMARMUX}, if_b.PCMUX,
                      {if_b.DRMUX, if_b.SR1MUX, if_b.SR2MUX, if_b.ADDR1MUX}, if_b.ADDR2MUX, if_b.ALUK,
                      if_b.Mem_OE, if_b.Mem_WE);
  assign obs_c = pack({if_c.LD_MAR, if_c.LD_MDR, if_c.LD_IR, if_c.LD_BEN, if_c.LD_CC, if_c.LD_REG, if_c.LD_PC, if_c.LD_LED},
                      {if_c.GatePC, if_c.GateMDR, if_c.GateALU, if_c.GateMARMUX}, if_c.PCMUX,
                      {if_c.DRMUX, if_c.SR1MUX, if_c.SR2MUX, if_c.ADDR1MUX}, if_c.ADDR2MUX, if_c.ALUK,
                      if_c.Mem_OE, if_c.Mem_WE);

  typedef struct {
    logic        run;
    logic        cont;
    logic [3:0]  op;
    logic        ir5;
    logic        ir11;
    logic        ben;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[$];
  vec_t cur;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %06h expected %06h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [23:0] obs_of(input int which);
    case (which)
      0:       return obs_a;
      1:       return obs_b;
      default: return obs_c;
    endcase
  endfunction

  task automatic drive(input int which, input vec_t v);
    case (which)
      0: begin
        if_a.Run = v.run; if_a.Continue = v.cont; if_a.Opcode = v.op;
        if_a.IR_5 = v.ir5; if_a.IR_11 = v.ir11; if_a.BEN = v.ben;
      end
      1: begin
        if_b.Run = v.run; if_b.Continue = v.cont; if_b.Opcode = v.op;
        if_b.IR_5 = v.ir5; if_b.IR_11 = v.ir11; if_b.BEN = v.ben;
      end
      default: begin
        if_c.Run = v.run; if_c.Continue = v.cont; if_c.Opcode = v.op;
        if_c.IR_5 = v.ir5; if_c.IR_11 = v.ir11; if_c.BEN = v.ben;
      end
    endcase
  endtask

  // Drive inputs, let the comb outputs settle, compare, then advance one clock.
  task automatic step(input int which, input vec_t v, input string name);
    drive(which, v);
    #1;
    check(name, obs_of(which), v.exp);
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ins(input logic [3:0] op, input logic ir5, input logic ir11,
                         input logic ben, input logic run, input logic cont);
    cur.op = op; cur.ir5 = ir5; cur.ir11 = ir11; cur.ben = ben; cur.run = run; cur.cont = cont;
  endtask

  task automatic add(input logic [23:0] exp);
    vec_t v;
    v = cur;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  // Fetch + decode for MEM_WAIT = 4: S18, four RD_IF cycles, S35, S32.
  task automatic add_fetch();
    add(E_FETCH);
    add(E_RD); add(E_RD); add(E_RD); add(E_RDL);
    add(E_S35);
    add(E_S32);
  endtask

  task automatic cstep(input int which, input logic run, input logic cont, input logic [3:0] op,
                       input logic [23:0] exp, input string name);
    vec_t v;
    v = '{run: run, cont: cont, op: op, ir5: 1'b0, ir11: 1'b0, ben: 1'b0, exp: exp};
    step(which, v, name);
  endtask

  initial begin
    int  we_n;
    int  oe_n;
    bit  back;
    vec_t idle;

    idle = '{run: 1'b0, cont: 1'b0, op: 4'b0000, ir5: 1'b0, ir11: 1'b0, ben: 1'b0, exp: 24'h0};
    drive(0, idle); drive(1, idle); drive(2, idle);
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_a", obs_a, 24'h0);
    check("reset_b", obs_b, 24'h0);
    check("reset_c", obs_c, 24'h0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Main program on dut_a; Run stays high through the whole ADD to show it is ignored.
    set_ins(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    add(24'h0);
    add_fetch(); add(G_ALU | LD_REG | LD_CC | SR1_86 | SR2_IM);
    set_ins(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_fetch(); add(G_ALU | LD_REG | LD_CC | SR1_86 | K_AND);
    set_ins(4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_fetch(); add(G_ALU | LD_REG | LD_CC | SR1_86 | SR2_IM | K_NOT);
    set_ins(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_fetch(); add(24'h0);
    set_ins(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_fetch(); add(24'h0); add(LD_PC | PC_ADR | A2_O9);
    set_ins(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_fetch(); add(SR1_86 | K_PASS | G_ALU | LD_PC | PC_BUS);
    set_ins(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_fetch(); add(G_PC | LD_REG | DR_R7); add(LD_PC | PC_ADR | SR1_86 | A1_SR1);
    set_ins(4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add_fetch(); add(G_PC | LD_REG | DR_R7); add(LD_PC | PC_ADR | A2_O11);
    set_ins(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_fetch(); add(E_MARB);
    add(E_RD); add(E_RD); add(E_RD); add(E_RDL);
    add(G_MDR | LD_REG | LD_CC);
    set_ins(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_fetch(); add(E_MARB); add(K_PASS | G_ALU | LD_MDR);
    add(M_WE); add(M_WE); add(M_WE); add(M_WE);
    set_ins(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_fetch();

    for (int i = 0; i < tbl.size(); i++) step(0, tbl[i], $sformatf("tbl[%0d]", i));

    // PAUSE: LD_LED through 10 low cycles, then a Continue pulse; fetch one cycle after it falls.
    for (int i = 0; i < 7; i++) begin
      cstep(0, 1'b0, 1'b0, 4'b1101, (i == 0) ? E_FETCH : (i < 4) ? E_RD : (i == 4) ? E_RDL :
                                    (i == 5) ? E_S35 : E_S32, $sformatf("pause_fetch[%0d]", i));
    end
    for (int i = 0; i < 10; i++) cstep(0, 1'b0, 1'b0, 4'b1101, LD_LED, $sformatf("pause_wait[%0d]", i));
    cstep(0, 1'b0, 1'b1, 4'b1101, LD_LED, "pause_cont_hi");
    cstep(0, 1'b0, 1'b1, 4'b1101, 24'h0, "pause_s14_hold");
    cstep(0, 1'b0, 1'b0, 4'b1101, 24'h0, "pause_s14_fall");
    cstep(0, 1'b0, 1'b0, 4'b1101, E_FETCH, "pause_resume");

    // Second PAUSE, then asynchronous reset while waiting for Continue.
    for (int i = 1; i < 7; i++) begin
      cstep(0, 1'b0, 1'b0, 4'b1101, (i < 4) ? E_RD : (i == 4) ? E_RDL : (i == 5) ? E_S35 : E_S32,
            $sformatf("pause2_fetch[%0d]", i));
    end
    cstep(0, 1'b0, 1'b0, 4'b1101, LD_LED, "pause2_wait0");
    cstep(0, 1'b0, 1'b0, 4'b1101, LD_LED, "pause2_wait1");
    #1;
    Reset_n = 1'b0;
    #1;
    check("async_reset_a", obs_a, 24'h0);
    @(posedge Clk);
    #1;
    check("reset_hold_a", obs_a, 24'h0);
    Reset_n = 1'b1;
    cstep(0, 1'b0, 1'b0, 4'b1101, 24'h0, "halted_idle");
    cstep(0, 1'b1, 1'b0, 4'b1101, 24'h0, "halted_run");
    cstep(0, 1'b0, 1'b0, 4'b1101, E_FETCH, "restart_fetch");

    // dut_b, MEM_WAIT = 2: STR with a counted write phase.
    cstep(1, 1'b1, 1'b0, 4'b0111, 24'h0, "b_halted");
    cstep(1, 1'b0, 1'b0, 4'b0111, E_FETCH, "b_fetch");
    cstep(1, 1'b0, 1'b0, 4'b0111, E_RD, "b_rd0");
    cstep(1, 1'b0, 1'b0, 4'b0111, E_RDL, "b_rd1");
    cstep(1, 1'b0, 1'b0, 4'b0111, E_S35, "b_s35");
    cstep(1, 1'b0, 1'b0, 4'b0111, E_S32, "b_s32");
    cstep(1, 1'b0, 1'b0, 4'b0111, E_MARB, "b_s07");
    cstep(1, 1'b0, 1'b0, 4'b0111, K_PASS | G_ALU | LD_MDR, "b_s23");
    we_n = 0;
    oe_n = 0;
    back = 1'b0;
    for (int i = 0; i < 10 && !back; i++) begin
      if (obs_b == E_FETCH) begin
        back = 1'b1;
      end else begin
        if (if_b.Mem_WE) we_n++;
        if (if_b.Mem_OE) oe_n++;
        @(posedge Clk);
        #1;
      end
    end
    check_int("b_str_return", int'(back), 1);
    check_int("b_str_we_cycles", we_n, 2);
    check_int("b_str_oe_cycles", oe_n, 0);

    // dut_c, MEM_WAIT = 1 with the IR pause loop compiled in.
    cstep(2, 1'b1, 1'b0, 4'b0001, 24'h0, "c_halted");
    cstep(2, 1'b0, 1'b0, 4'b0001, E_FETCH, "c_fetch");
    cstep(2, 1'b0, 1'b0, 4'b0001, E_RDL, "c_rd");
    cstep(2, 1'b0, 1'b0, 4'b0001, E_S35, "c_s35");
    cstep(2, 1'b0, 1'b0, 4'b0001, 24'h0, "c_pir1_a");
    cstep(2, 1'b0, 1'b0, 4'b0001, 24'h0, "c_pir1_b");
    cstep(2, 1'b0, 1'b1, 4'b0001, 24'h0, "c_pir1_cont");
    cstep(2, 1'b0, 1'b1, 4'b0001, 24'h0, "c_pir2_hold");
    cstep(2, 1'b0, 1'b0, 4'b0001, 24'h0, "c_pir2_fall");
    cstep(2, 1'b0, 1'b0, 4'b0001, E_FETCH, "c_refetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc3_isdu_param.md
# lc3_isdu_param

Parametrised LC-3 instruction sequencing and decode unit (ISDU) for the Lab 6 SLC-3 datapath. It drives the register, gate, mux and memory-strobe controls for fetch, decode and the full lab instruction set: ADD, AND, NOT, BR, JMP, JSR/JSRR, LDR, STR and PAUSE. SRAM access length is a parameter, implemented with a down-counter rather than fixed chained states. The week-1 IR pause loop is compile-time optional.

## Interface
- MEM_WAIT, 4: cycles Mem_OE/Mem_WE are held per SRAM access; legal range 1..15.
- PAUSE_EN, 0: 1 inserts the PAUSE_IR1/PAUSE_IR2 loop after every IR load.
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Run, Continue  in  1  synchronised front-panel buttons, active-high.
- Opcode  in  4  IR[15:12].
- IR_5, IR_11  in  1  IR[5] (immediate select) and IR[11] (JSR/JSRR select).
- BEN  in  1  registered branch-enable.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  out  1  bus drivers, one-hot or all zero.
- PCMUX  out  2  00 = PC+1, 01 = bus, 10 = address adder.
- DRMUX  out  1  0 = IR[11:9], 1 = R7.
- SR1MUX  out  1  0 = IR[11:9], 1 = IR[8:6].
- SR2MUX  out  1  0 = register, 1 = SEXT(imm5).
- ADDR1MUX  out  1  0 = PC, 1 = SR1.
- ADDR2MUX  out  2  00 = 0, 01 = off6, 10 = off9, 11 = off11.
- ALUK  out  2  00 = ADD, 01 = AND, 10 = NOT, 11 = PASS A.
- Mem_OE, Mem_WE  out  1  SRAM strobes, active-high. The MDR input mux selects SRAM when Mem_OE = 1, otherwise the bus.

## Operation
- Outputs are Moore and combinational from state. Every output not listed for a state is 0.
- HALTED: idle. Run = 1 moves to S18.
- S18 (fetch): MAR <- PC and PC <- PC+1. Asserts GatePC, LD_MAR, LD_PC, PCMUX = 00. Loads the wait counter with MEM_WAIT-1, then goes to RD_IF.
- RD_IF: asserts Mem_OE and decrements the counter. On the cycle the counter is 0, also asserts LD_MDR and goes to S35.
- S35: asserts GateMDR and LD_IR. Goes to PAUSE_IR1 if PAUSE_EN = 1, otherwise S32.
- PAUSE_IR1 waits for Continue = 1, then PAUSE_IR2 waits for Continue = 0, then S18.
- S32: asserts LD_BEN and dispatches on Opcode:
  - 0001 -> S01, 0101 -> S05, 1001 -> S09, 0000 -> S00, 1100 -> S12, 0100 -> S04, 0110 -> S06, 0111 -> S07, 1101 -> S13.
  - Any other opcode -> S18 (treated as NOP).
- S01, S05, S09 (ADD, AND, NOT): ALUK = 00, 01 or 10 respectively. Assert GateALU, LD_REG, LD_CC, DRMUX = 0, SR1MUX = 1, SR2MUX = IR_5. Then S18.
- S00 (BR): BEN = 1 -> S22, else S18.
- S22: PC <- PC+off9. LD_PC, ADDR1MUX = 0, ADDR2MUX = 10, PCMUX = 10. Then S18.
- S12 (JMP): PC <- BaseR. SR1MUX = 1, ALUK = 11, GateALU, LD_PC, PCMUX = 01. Then S18.
- S04: R7 <- PC. GatePC, LD_REG, DRMUX = 1. Then S21.
- S21 (JSR/JSRR), with LD_PC and PCMUX = 10 in both cases:
  - IR_11 = 1: ADDR1MUX = 0, ADDR2MUX = 11.
  - IR_11 = 0: SR1MUX = 1, ADDR1MUX = 1, ADDR2MUX = 00.
  - Then S18.
- S06 (LDR): MAR <- BaseR+off6. SR1MUX = 1, ADDR1MUX = 1, ADDR2MUX = 01, GateMARMUX, LD_MAR. Loads the counter, then S25.
- S25: same read behaviour as RD_IF, then S27.
- S27: GateMDR, LD_REG, LD_CC, DRMUX = 0. Then S18.
- S07 (STR): same MAR load as S06, then S23.
- S23: MDR <- SR via SR1MUX = 0, ALUK = 11, GateALU, LD_MDR, Mem_OE = 0. Loads the counter, then S16.
- S16: asserts Mem_WE for MEM_WAIT cycles, then S18.
- S13 (PAUSE): asserts LD_LED while waiting for Continue = 1. Then S14 waits for Continue = 0, then S18.
- Counter width is $clog2(MEM_WAIT+1). It resets to 0. MEM_WAIT outside 1..15 is an elaboration error.

## Timing
- Reset_n low asynchronously forces HALTED and counter = 0. All outputs go to 0 within the same cycle, including mid-access or mid-pause.
- Instruction cost with PAUSE_EN = 0 is 1 + MEM_WAIT + 2 cycles (S18 + RD_IF + S35 + S32) plus execute:
  - ADD/AND/NOT/JMP/NOP: +1.
  - BR taken: +2. BR not taken: +1.
  - JSR: +2.
  - LDR: +MEM_WAIT+2.
  - STR: +MEM_WAIT+2.
- Mem_OE is never asserted on the same cycle as Mem_WE.
- At most one Gate* is asserted per cycle.
- LD_BEN is asserted only in S32, so the S00 branch decision uses BEN registered one cycle earlier.
- Run is sampled only in HALTED; Run held high during execution has no effect.

## Test plan
- Reset with MEM_WAIT = 4, PAUSE_EN = 0, Run pulsed at cycle 0 -> S18 at cycle 1; Mem_OE high for cycles 2-5; LD_MDR at cycle 5 only; LD_IR at cycle 6; LD_BEN at cycle 7.
- ADD with IR_5 = 1 -> execute cycle shows GateALU = 1, LD_REG = 1, LD_CC = 1, SR2MUX = 1, ALUK = 00, then back to S18; 8 cycles per instruction in total.
- STR with MEM_WAIT = 2 -> S07 GateMARMUX + LD_MAR; S23 LD_MDR with Mem_OE = 0; Mem_WE high for exactly 2 cycles; Mem_OE never high during the execute phase.
- BR with BEN = 0, then again with BEN = 1 -> not-taken returns to S18 with no LD_PC; taken shows LD_PC, PCMUX = 10, ADDR2MUX = 10.
- JSRR (IR_11 = 0) -> S04 DRMUX = 1 + GatePC; S21 ADDR1MUX = 1, ADDR2MUX = 00, LD_PC.
- PAUSE opcode 1101 with Continue held low 10 cycles, then a high/low pulse -> LD_LED high for all 10 cycles; fetch resumes one cycle after Continue falls. Reset_n dropped mid-wait -> all outputs 0 immediately, state HALTED.
